lsq_addr_gen: RTL and testbench
===============================

// Module: lsq_addr_gen
// PURPOSE
//  Address-generation reservation station directly upstream of the load/store queue. Holds
//  dispatched loads/stores until base register rs1 is available (at dispatch or by CDB wakeup).
//  Computes rs1 + sext(imm) and presents {addr, rob_index} to the CDB arbiter, which broadcasts
//  it on a cdb_loadstore lane so the LSQ can fill in the memory address.
// PARAMETERS
//  AGU_RS_SIZE    8   number of station entries
//  REG_SIZE       32  data/address width
//  NUM_TAGS       64  physical tag space; tag 0 = "no producer", never matches
//  ROB_SIZE       64  ROB entries; ROB index width = $clog2(ROB_SIZE)
//  NUM_CDB        3   CDB lanes snooped for wakeup
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  flush          in   1             squash all entries and output (mispredict recovery)
//  in_valid       in   1             dispatch a memory op this cycle
//  in_ready       out  1             station has at least one free entry
//  in_rob_index   in   ROB_LOG2      ROB slot of the op (same value the LSQ records)
//  in_tag_rs1     in   TAG_LOG2      producer tag of rs1
//  in_rs1_ready   in   1             rs1 value valid on in_rs1_data (from ROB/ARF)
//  in_rs1_data    in   REG_SIZE      rs1 value when ready
//  in_imm         in   12            raw I/S-type immediate
//  in_is_word     in   1             1 = word access, 0 = byte
//  cdb_tags       in   TAG_LOG2 x3   CDB result tags
//  cdb_data       in   REG_SIZE x3   CDB result data
//  cdb_valid      in   1 x3          CDB lane valid
//  agu_valid      out  1             output holds a computed address
//  agu_ready      in   1             CDB arbiter accepts output this cycle
//  agu_addr       out  REG_SIZE      rs1 + sext(imm)
//  agu_rob_index  out  ROB_LOG2      ROB index matching agu_addr
//  agu_misaligned out  1             word access with addr[1:0] != 0 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset or flush: all entries are invalid. agu_valid=0, agu_addr=0, agu_rob_index=0,
//    agu_misaligned=0, in_ready=1 next cycle. Flush beats a simultaneous in_valid.
//  - in_ready = !(all entries valid), computed from registered state only. A slot freed this
//    cycle is not reusable until next cycle. in_valid while !in_ready is ignored.
//  - Allocation goes to the lowest-index free entry. The entry stores rob_index, tag_rs1, imm,
//    and is_word. rs1 is marked ready if in_rs1_ready, or if in_tag_rs1 != 0 matches a valid
//    CDB lane in the same cycle. The lowest CDB lane wins; its data is captured.
//  - Wakeup: each cycle, every valid, not-ready entry compares tag_rs1 against each valid CDB
//    lane with a nonzero tag. On a match it captures the data and sets ready at the edge. The
//    entry is eligible for select the following cycle.
//  - Select: the lowest-index valid and ready entry. It is taken when output is empty or
//    agu_ready=1. At the edge, the output register loads addr = rs1 + {{20{imm[11]}}, imm},
//    mod 2^32, and the entry is freed.
//  - Output handshake: agu_valid, agu_addr, and agu_rob_index are held stable until
//    agu_valid && agu_ready. On accept with no eligible entry, agu_valid drops next cycle.
//  - Throughput is 1 address/cycle with agu_ready held high.
//  - Latency: dispatch with rs1 ready at cycle 0 gives agu_valid in cycle 2.
//    CDB wakeup in cycle c gives agu_valid in cycle c+2.
//  - Backpressure: while agu_valid && !agu_ready, no entry is freed. Wakeup and allocation
//    continue.
// CONFIGURATION
//  AGU_ALIGN_CHECK_EN defined: agu_misaligned = is_word && addr[1:0] != 0, registered with
//    agu_addr. The address is still issued unchanged.
//  Undefined: agu_misaligned is tied to 0 and no alignment logic is built.
// STRUCTURE
//  agu_pkg: ROB_LOG2 and TAG_LOG2 localparams, NUM_CDB, agu_entry_t struct
//    {valid, rs1_rdy, rob_idx, tag_rs1, rs1_val, imm, is_word}, sext12() function.
//  Sub-module agu_pick: parameterised lowest-index one-hot picker, instanced twice
//    (free-slot allocation and ready-entry selection).
// TESTING
//  1 Dispatch rob=5, rs1_ready, rs1=0x10, imm=0x004, word, agu_ready=1
//    -> cycle 2: agu_valid=1, addr=0x14, rob=5, misaligned=0.
//  2 Dispatch rob=7, tag_rs1=9 not ready, imm=0xFFF; cycle 4 CDB lane1 tag 9 data 0x20
//    -> cycle 6: addr=0x1F, rob=7.
//  3 Fill 8 entries not ready -> in_ready=0; 9th in_valid ignored. Wake entry 3
//    -> issues; in_ready=1 one cycle after free.
//  4 agu_ready=0 with output rob=2 and entries 0,1 ready -> output held 5 cycles.
//    Raise agu_ready -> rob=2, then entry 0, then entry 1 on consecutive cycles.
//  5 CDB tag 0 with data 0xDEAD while an entry waits on tag 0 -> no wakeup.
//    Flush mid-backpressure -> agu_valid=0 and in_ready=1 next cycle.
//  6 With AGU_ALIGN_CHECK_EN: word, rs1=0x3, imm=0 -> agu_misaligned=1.
//    Byte at the same address -> 0.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared types and sizing for the load/store address-generation station.
// Optional feature macro: AGU_ALIGN_CHECK_EN (word alignment flag on the output).
package agu_pkg;

  localparam int AGU_RS_SIZE = 8;
  localparam int REG_SIZE    = 32;
  localparam int NUM_TAGS    = 64;
  localparam int ROB_SIZE    = 64;
  localparam int NUM_CDB     = 3;
  localparam int ROB_LOG2    = $clog2(ROB_SIZE);
  localparam int TAG_LOG2    = $clog2(NUM_TAGS);

  // One station slot; rs1_val is meaningful only once rs1_rdy is set.
  typedef struct packed {
    logic                valid;
    logic                rs1_rdy;
    logic [ROB_LOG2-1:0] rob_idx;
    logic [TAG_LOG2-1:0] tag_rs1;
    logic [REG_SIZE-1:0] rs1_val;
    logic [11:0]         imm;
    logic                is_word;
  } agu_entry_t;

  // Sign-extend a 12-bit I/S-type immediate to the datapath width.
  function automatic logic [REG_SIZE-1:0] sext12(input logic [11:0] imm);
    return {{(REG_SIZE-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/agu_pick.sv
// Lowest-index one-hot picker; used for free-slot allocation and ready-entry select.
module agu_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Isolate the lowest set bit with the two's-complement trick.
  always_comb begin
    gnt = req & (~req + N'(1));
    any = |req;
  end

endmodule

// File: rtl/lsq_addr_gen.sv
// Address-generation reservation station feeding the CDB arbiter for the LSQ.
// Holds memory ops until rs1 is known, computes rs1 + sext(imm), and issues
// {addr, rob_index} through a single valid/ready output register.
// Optional feature macro: AGU_ALIGN_CHECK_EN (drives agu_misaligned for word ops).
module lsq_addr_gen
  import agu_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ROB_LOG2-1:0]                in_rob_index,
  input  logic [TAG_LOG2-1:0]                in_tag_rs1,
  input  logic                               in_rs1_ready,
  input  logic [REG_SIZE-1:0]                in_rs1_data,
  input  logic [11:0]                        in_imm,
  input  logic                               in_is_word,
  input  logic [NUM_CDB-1:0][TAG_LOG2-1:0]   cdb_tags,
  input  logic [NUM_CDB-1:0][REG_SIZE-1:0]   cdb_data,
  input  logic [NUM_CDB-1:0]                 cdb_valid,
  output logic                               agu_valid,
  input  logic                               agu_ready,
  output logic [REG_SIZE-1:0]                agu_addr,
  output logic [ROB_LOG2-1:0]                agu_rob_index,
  output logic                               agu_misaligned
);

  agu_entry_t ent [AGU_RS_SIZE];

  logic [AGU_RS_SIZE-1:0] vld_vec, rdy_vec, free_vec;
  logic [AGU_RS_SIZE-1:0] alloc_oh, sel_oh;
  logic                   alloc_any, sel_any;
  logic                   alloc_en, take;

  logic                   disp_hit;
  logic [REG_SIZE-1:0]    disp_data;
  agu_entry_t             new_ent;

  logic [AGU_RS_SIZE-1:0] wk_hit;
  logic [REG_SIZE-1:0]    wk_data [AGU_RS_SIZE];

  logic [REG_SIZE-1:0]    sel_val;
  logic [11:0]            sel_imm;
  logic [ROB_LOG2-1:0]    sel_rob;
  logic [REG_SIZE-1:0]    sel_addr;

  // Occupancy and eligibility vectors from registered entry state only.
  always_comb begin
    for (int i = 0; i < AGU_RS_SIZE; i++) begin
      vld_vec[i] = ent[i].valid;
      rdy_vec[i] = ent[i].valid & ent[i].rs1_rdy;
    end
    free_vec = ~vld_vec;
  end

  agu_pick #(.N(AGU_RS_SIZE)) u_alloc_pick (
    .req (free_vec),
    .gnt (alloc_oh),
    .any (alloc_any)
  );

  agu_pick #(.N(AGU_RS_SIZE)) u_sel_pick (
    .req (rdy_vec),
    .gnt (sel_oh),
    .any (sel_any)
  );

  // A free slot exists iff not every entry is valid; slots freed this cycle
  // only show up next cycle because this looks at registered state.
  assign in_ready = alloc_any;
  assign alloc_en = in_valid & in_ready & ~flush;
  // The output register can take a new address when empty or being drained.
  assign take     = sel_any & (~agu_valid | agu_ready);

  // Dispatch-time operand capture: ROB/ARF value first, else lowest matching CDB lane.
  always_comb begin
    disp_hit  = 1'b0;
    disp_data = in_rs1_data;
    if (!in_rs1_ready && in_tag_rs1 != '0) begin
      for (int j = NUM_CDB - 1; j >= 0; j--) begin
        if (cdb_valid[j] && cdb_tags[j] == in_tag_rs1) begin
          disp_hit  = 1'b1;
          disp_data = cdb_data[j];
        end
      end
    end
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.rs1_rdy = in_rs1_ready | disp_hit;
    new_ent.rob_idx = in_rob_index;
    new_ent.tag_rs1 = in_tag_rs1;
    new_ent.rs1_val = disp_data;
    new_ent.imm     = in_imm;
    new_ent.is_word = in_is_word;
  end

  // Per-entry CDB snoop; descending loop lets the lowest matching lane win.
  always_comb begin
    for (int i = 0; i < AGU_RS_SIZE; i++) begin
      wk_hit[i]  = 1'b0;
      wk_data[i] = ent[i].rs1_val;
      for (int j = NUM_CDB - 1; j >= 0; j--) begin
        if (ent[i].valid && !ent[i].rs1_rdy && cdb_valid[j] &&
            cdb_tags[j] != '0 && cdb_tags[j] == ent[i].tag_rs1) begin
          wk_hit[i]  = 1'b1;
          wk_data[i] = cdb_data[j];
        end
      end
    end
  end

  // Entry state: allocate into a free slot, free on select, capture wakeups.
  always_ff @(posedge clk) begin
    for (int i = 0; i < AGU_RS_SIZE; i++) begin
      if (rst || flush) begin
        ent[i] <= '0;
      end else if (alloc_en && alloc_oh[i]) begin
        ent[i] <= new_ent;
      end else if (take && sel_oh[i]) begin
        ent[i].valid <= 1'b0;
      end else if (wk_hit[i]) begin
        ent[i].rs1_rdy <= 1'b1;
        ent[i].rs1_val <= wk_data[i];
      end
    end
  end

  // One-hot mux of the selected entry's operands.
  always_comb begin
    sel_val = '0;
    sel_imm = '0;
    sel_rob = '0;
    for (int i = 0; i < AGU_RS_SIZE; i++) begin
      if (sel_oh[i]) begin
        sel_val = sel_val | ent[i].rs1_val;
        sel_imm = sel_imm | ent[i].imm;
        sel_rob = sel_rob | ent[i].rob_idx;
      end
    end
    sel_addr = sel_val + sext12(sel_imm);
  end

  // Output register: load on take, drop valid when drained with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      agu_valid     <= 1'b0;
      agu_addr      <= '0;
      agu_rob_index <= '0;
    end else if (take) begin
      agu_valid     <= 1'b1;
      agu_addr      <= sel_addr;
      agu_rob_index <= sel_rob;
    end else if (agu_ready) begin
      agu_valid     <= 1'b0;
    end
  end

`ifdef AGU_ALIGN_CHECK_EN
  logic sel_word;
  logic mis_q;

  // Word flag of the selected entry, for the alignment check.
  always_comb begin
    sel_word = 1'b0;
    for (int i = 0; i < AGU_RS_SIZE; i++) begin
      if (sel_oh[i]) sel_word = sel_word | ent[i].is_word;
    end
  end

  // Misalignment flag travels with agu_addr; the address itself is unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mis_q <= 1'b0;
    end else if (take) begin
      mis_q <= sel_word & (sel_addr[1:0] != 2'b00);
    end
  end

  assign agu_misaligned = mis_q;
`else
  assign agu_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_lsq_addr_gen.sv
// Scoreboard bench for lsq_addr_gen: stimulus pushes expected issues, a monitor
// pops and compares on every accepted output; directed checks cover timing.
module tb_lsq_addr_gen;
  import agu_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst, flush, in_valid, in_ready;
  logic [ROB_LOG2-1:0]              in_rob_index;
  logic [TAG_LOG2-1:0]              in_tag_rs1;
  logic                             in_rs1_ready;
  logic [REG_SIZE-1:0]              in_rs1_data;
  logic [11:0]                      in_imm;
  logic                             in_is_word;
  logic [NUM_CDB-1:0][TAG_LOG2-1:0] cdb_tags;
  logic [NUM_CDB-1:0][REG_SIZE-1:0] cdb_data;
  logic [NUM_CDB-1:0]               cdb_valid;
  logic                             agu_valid, agu_ready, agu_misaligned;
  logic [REG_SIZE-1:0]              agu_addr;
  logic [ROB_LOG2-1:0]              agu_rob_index;

  lsq_addr_gen dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_index(in_rob_index),
    .in_tag_rs1(in_tag_rs1), .in_rs1_ready(in_rs1_ready), .in_rs1_data(in_rs1_data),
    .in_imm(in_imm), .in_is_word(in_is_word),
    .cdb_tags(cdb_tags), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .agu_valid(agu_valid), .agu_ready(agu_ready), .agu_addr(agu_addr),
    .agu_rob_index(agu_rob_index), .agu_misaligned(agu_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  rob;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_mis(input logic w, input logic [31:0] a);
    logic m;
    m = w & (a[1:0] != 2'b00);
`ifndef AGU_ALIGN_CHECK_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  task automatic push(input logic [31:0] a, input logic [5:0] r, input logic w);
    exp_t e;
    e.addr = a;
    e.rob  = r;
    e.mis  = exp_mis(w, a);
    sbq.push_back(e);
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && agu_valid && agu_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got rob %0d addr 0x%0h want no issue", agu_rob_index, agu_addr);
      end else begin
        e = sbq.pop_front();
        chk("sb_addr", agu_addr, e.addr);
        chk("sb_rob", 32'(agu_rob_index), 32'(e.rob));
        chk("sb_mis", 32'(agu_misaligned), 32'(e.mis));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input int rob, input int tag, input logic rdy,
                          input logic [31:0] data, input logic [11:0] imm, input logic w);
    in_valid     = 1'b1;
    in_rob_index = ROB_LOG2'(rob);
    in_tag_rs1   = TAG_LOG2'(tag);
    in_rs1_ready = rdy;
    in_rs1_data  = data;
    in_imm       = imm;
    in_is_word   = w;
  endtask

  task automatic clr_disp();
    in_valid     = 1'b0;
    in_rs1_ready = 1'b0;
    in_tag_rs1   = '0;
  endtask

  task automatic set_cdb(input int lane, input int tag, input logic [31:0] data);
    cdb_valid[lane] = 1'b1;
    cdb_tags[lane]  = TAG_LOG2'(tag);
    cdb_data[lane]  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; agu_ready = 1'b1;
    clr_disp();
    in_rob_index = '0; in_rs1_data = '0; in_imm = '0; in_is_word = 1'b0;
    cdb_tags = '0; cdb_data = '0; cdb_valid = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(agu_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_addr", agu_addr, 0);
    chk("rst_rob", 32'(agu_rob_index), 0);
    chk("rst_mis", 32'(agu_misaligned), 0);

    // 1: ready at dispatch -> agu_valid in cycle 2
    set_disp(5, 0, 1'b1, 32'h10, 12'h004, 1'b1);
    push(32'h14, 6'd5, 1'b1);
    tick(); clr_disp();
    chk("t1_cyc1_valid", 32'(agu_valid), 0);
    tick();
    chk("t1_cyc2_valid", 32'(agu_valid), 1);
    chk("t1_addr", agu_addr, 32'h14);
    tick();
    chk("t1_drop", 32'(agu_valid), 0);

    // 2: CDB wakeup in cycle 4 -> agu_valid in cycle 6, negative immediate
    set_disp(7, 9, 1'b0, 32'h0, 12'hFFF, 1'b0);
    push(32'h1F, 6'd7, 1'b0);
    tick(); clr_disp();
    repeat (3) tick();
    chk("t2_wait_valid", 32'(agu_valid), 0);
    set_cdb(1, 9, 32'h20);
    tick(); cdb_valid = '0;
    chk("t2_cyc5_valid", 32'(agu_valid), 0);
    tick();
    chk("t2_cyc6_valid", 32'(agu_valid), 1);
    chk("t2_rob", 32'(agu_rob_index), 7);
    tick();

    // 3: fill all 8 entries, 9th ignored, wake entry 3
    for (int i = 0; i < 8; i++) begin
      set_disp(10 + i, 20 + i, 1'b0, 32'h0, 12'(i * 4), 1'b1);
      tick();
    end
    clr_disp();
    chk("t3_full", 32'(in_ready), 0);
    set_disp(30, 40, 1'b1, 32'h100, 12'h0, 1'b1);
    tick(); clr_disp();
    tick();
    chk("t3_ignored", 32'(agu_valid), 0);
    set_cdb(0, 23, 32'h300);
    push(32'h30C, 6'd13, 1'b1);
    tick(); cdb_valid = '0;
    chk("t3_still_full", 32'(in_ready), 0);
    tick();
    chk("t3_freed", 32'(in_ready), 1);
    chk("t3_valid", 32'(agu_valid), 1);
    tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("t3_flush_valid", 32'(agu_valid), 0);
    chk("t3_flush_ready", 32'(in_ready), 1);

    // 4: backpressure holds rob=2, then entry 0 (rob4), then entry 1 (rob3)
    agu_ready = 1'b0;
    set_disp(2, 0, 1'b1, 32'h1000, 12'h010, 1'b1);
    push(32'h1010, 6'd2, 1'b1);
    tick();
    set_disp(3, 0, 1'b1, 32'h2000, 12'h7FF, 1'b0);
    tick();
    set_disp(4, 0, 1'b1, 32'h3000, 12'h800, 1'b1);
    tick(); clr_disp();
    push(32'h2800, 6'd4, 1'b1);
    push(32'h27FF, 6'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(agu_valid), 1);
      chk("t4_hold_rob", 32'(agu_rob_index), 2);
      chk("t4_hold_addr", agu_addr, 32'h1010);
      tick();
    end
    agu_ready = 1'b1;
    tick();
    chk("t4_second_rob", 32'(agu_rob_index), 4);
    tick();
    chk("t4_third_rob", 32'(agu_rob_index), 3);
    tick();
    chk("t4_empty", 32'(agu_valid), 0);

    // Throughput: one address per cycle
    for (int i = 0; i < 4; i++) begin
      set_disp(40 + i, 0, 1'b1, 32'h100, 12'(i), 1'b0);
      push(32'h100 + 32'(i), 6'(40 + i), 1'b0);
      tick();
      if (i >= 1) chk("tp_valid", 32'(agu_valid), 1);
    end
    clr_disp();
    chk("tp_rob42", 32'(agu_rob_index), 42);
    tick();
    chk("tp_rob43", 32'(agu_rob_index), 43);
    tick();
    chk("tp_drain", 32'(agu_valid), 0);

    // 5: tag 0 never wakes; flush during backpressure beats in_valid
    set_disp(20, 0, 1'b0, 32'h0, 12'h0, 1'b1);
    tick(); clr_disp();
    set_cdb(0, 0, 32'hDEAD);
    tick(); cdb_valid = '0;
    tick(); tick();
    chk("t5_tag0_nowake", 32'(agu_valid), 0);
    agu_ready = 1'b0;
    set_disp(21, 0, 1'b1, 32'h40, 12'h0, 1'b1);
    tick(); clr_disp();
    tick();
    chk("t5_bp_valid", 32'(agu_valid), 1);
    chk("t5_bp_rob", 32'(agu_rob_index), 21);
    flush = 1'b1;
    set_disp(22, 0, 1'b1, 32'h80, 12'h0, 1'b1);
    tick(); flush = 1'b0; clr_disp();
    chk("t5_flush_valid", 32'(agu_valid), 0);
    chk("t5_flush_ready", 32'(in_ready), 1);
    chk("t5_flush_addr", agu_addr, 0);
    chk("t5_flush_rob", 32'(agu_rob_index), 0);
    agu_ready = 1'b1;
    repeat (3) tick();
    chk("t5_squashed", 32'(agu_valid), 0);

    // 6: alignment flag (expected value depends on build configuration)
    set_disp(50, 0, 1'b1, 32'h3, 12'h0, 1'b1);
    push(32'h3, 6'd50, 1'b1);
    tick();
    set_disp(51, 0, 1'b1, 32'h3, 12'h0, 1'b0);
    push(32'h3, 6'd51, 1'b0);
    tick(); clr_disp();
    chk("t6_word_mis", 32'(agu_misaligned), 32'(exp_mis(1'b1, 32'h3)));
    tick();
    chk("t6_byte_mis", 32'(agu_misaligned), 0);

    // Drain: everything pushed must have been issued
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
